dht_sensor_responder: RTL and testbench

// - Single-wire DHT11/DHT22 sensor emulator: the responder end of the humidity-sensor protocol.
// - Detects the host start pulse, answers with the 80/80 us presence sequence, then sends a 40-bit frame
//   (hum_int, hum_dec, temp_int, temp_dec, checksum), MSB first; open-drain, drives low only.
// - Sits on the board/sim top in place of a real sensor, wired to the same data pin as the humidity host.

---
 rtl/dht_pkg.sv | 36 +++
 rtl/dht_line_sync.sv | 36 +++
 rtl/dht_sensor_responder.sv | 160 ++++++++++++++++
 tb/tb_dht_sensor_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared DHT single-wire definitions: responder states, default protocol timing (cycles
// of a 1 MHz clock), and the frame checksum used by both the responder and the host.
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_WAIT_GO,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW
  } dht_state_t;

  localparam int unsigned DHT_T_START_MIN = 10000;
  localparam int unsigned DHT_T_GO        = 45;
  localparam int unsigned DHT_T_RESP      = 80;
  localparam int unsigned DHT_T_BIT_LOW   = 50;
  localparam int unsigned DHT_T_ZERO      = 26;
  localparam int unsigned DHT_T_ONE       = 70;
  localparam int unsigned DHT_FRAME_BITS  = 40;

  function automatic logic [7:0] dht_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] sum;
    sum = b0 + b1 + b2 + b3;
    return sum;
  endfunction

  // States in which the responder holds the wire low.
  function automatic logic dht_drives_low(input dht_state_t s);
    return (s == ST_RESP_LOW) || (s == ST_BIT_LOW) || (s == ST_STOP_LOW);
  endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the open-drain data wire with registered edge strobes.
// Flops reset to the pulled-up level so leaving reset never produces a false falling edge.
module dht_line_sync (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic level_reg;
  logic rise_reg;
  logic fall_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg  <= 1'b1;
      level_reg <= 1'b1;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      meta_reg  <= din;
      level_reg <= meta_reg;
      // Strobes are aligned with the cycle in which level first shows the new value.
      rise_reg  <= meta_reg & ~level_reg;
      fall_reg  <= ~meta_reg & level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/dht_sensor_responder.sv
// DHT11/DHT22 sensor emulator: accepts a host start pulse, answers with the presence
// sequence and shifts out a 40-bit humidity/temperature frame on an open-drain wire.
module dht_sensor_responder
  import dht_pkg::*;
#(
  parameter int unsigned T_START_MIN = DHT_T_START_MIN,
  parameter int unsigned T_GO        = DHT_T_GO,
  parameter int unsigned T_RESP      = DHT_T_RESP,
  parameter int unsigned T_BIT_LOW   = DHT_T_BIT_LOW,
  parameter int unsigned T_ZERO      = DHT_T_ZERO,
  parameter int unsigned T_ONE       = DHT_T_ONE
) (
  input  logic       clk1M,
  input  logic       rst,
  input  logic       dq_in,
  output logic       dq_pull_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] START_MIN     = 16'(T_START_MIN);
  localparam logic [15:0] GO_LAST       = 16'(T_GO - 1);
  localparam logic [15:0] RESP_LAST     = 16'(T_RESP - 1);
  localparam logic [15:0] BIT_LOW_LAST  = 16'(T_BIT_LOW - 1);
  localparam logic [15:0] ZERO_LAST     = 16'(T_ZERO - 1);
  localparam logic [15:0] ONE_LAST      = 16'(T_ONE - 1);
  localparam logic [5:0]  LAST_BIT      = 6'(DHT_FRAME_BITS - 1);

  dht_state_t  state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [5:0]  bit_idx_reg, bit_idx_next;
  logic [39:0] shadow_reg;
  logic        load_shadow;
  logic        pull_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] high_last;

  logic line_level;
  logic line_rise;
  logic line_fall;

  dht_line_sync u_line_sync (
    .clk   (clk1M),
    .srst  (rst),
    .din   (dq_in),
    .level (line_level),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  assign high_last = shadow_reg[bit_idx_reg] ? ONE_LAST : ZERO_LAST;

  // Every timed state lasts exactly N cycles: the timer runs 0..N-1 and is cleared on exit.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg + 16'd1;
    bit_idx_next = bit_idx_reg;
    load_shadow  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (line_fall) state_next = ST_START_LOW;
      end
      ST_START_LOW: begin
        timer_next = (line_level || timer_reg == 16'hFFFF) ? timer_reg : timer_reg + 16'd1;
        if (line_rise) begin
          timer_next = '0;
          if (timer_reg >= START_MIN) begin
            state_next  = ST_WAIT_GO;
            load_shadow = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_GO: begin
        if (timer_reg == GO_LAST) begin
          state_next = ST_RESP_LOW;
          timer_next = '0;
        end
      end
      ST_RESP_LOW: begin
        if (timer_reg == RESP_LAST) begin
          state_next = ST_RESP_HIGH;
          timer_next = '0;
        end
      end
      ST_RESP_HIGH: begin
        if (timer_reg == RESP_LAST) begin
          state_next   = ST_BIT_LOW;
          timer_next   = '0;
          bit_idx_next = LAST_BIT;
        end
      end
      ST_BIT_LOW: begin
        if (timer_reg == BIT_LOW_LAST) begin
          state_next = ST_BIT_HIGH;
          timer_next = '0;
        end
      end
      ST_BIT_HIGH: begin
        if (timer_reg == high_last) begin
          timer_next = '0;
          if (bit_idx_reg == 6'd0) begin
            state_next = ST_STOP_LOW;
          end else begin
            state_next   = ST_BIT_LOW;
            bit_idx_next = bit_idx_reg - 6'd1;
          end
        end
      end
      ST_STOP_LOW: begin
        if (timer_reg == BIT_LOW_LAST) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk1M) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      pull_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      pull_reg    <= dht_drives_low(state_next);
      busy_reg    <= (state_next != ST_IDLE) && (state_next != ST_START_LOW);
      done_reg    <= (state_reg == ST_STOP_LOW) && (state_next == ST_IDLE);
    end
  end

  always_ff @(posedge clk1M) begin
    if (load_shadow) begin
      shadow_reg <= {hum_int, hum_dec, temp_int, temp_dec,
                     dht_checksum(hum_int, hum_dec, temp_int, temp_dec)};
    end
  end

  assign dq_pull_low = pull_reg;
  assign busy        = busy_reg;
  assign frame_done  = done_reg;

endmodule

// File: tb/tb_dht_sensor_responder.sv
// Directed bench for dht_sensor_responder: plays the humidity host on an open-drain wire
// and measures every low/high run the responder produces, sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_dht_sensor_responder;

  localparam int T_GO      = 45;
  localparam int T_RESP    = 80;
  localparam int T_BIT_LOW = 50;
  localparam int T_ZERO    = 26;
  localparam int T_ONE     = 70;
  localparam int RUN_LIMIT = 2000;
  // Release reaches the FSM three edges later; the first edge precedes the first counted sample.
  localparam int EXP_LAT   = T_GO + 2;

  logic       clk1M = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic       dq_in;
  logic       dq_pull_low;
  logic       busy;
  logic       frame_done;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0, pull_count = 0, busy_count = 0;
  int lat, rl, rh, sl, bad_bits;
  logic [39:0] rx_bits;
  bit rx_timeout;

  assign dq_in = ~(host_low | dq_pull_low);
  always #5 clk1M = ~clk1M;

  dht_sensor_responder dut (
    .clk1M       (clk1M),
    .rst         (rst),
    .dq_in       (dq_in),
    .dq_pull_low (dq_pull_low),
    .hum_int     (hum_int),
    .hum_dec     (hum_dec),
    .temp_int    (temp_int),
    .temp_dec    (temp_dec),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always @(negedge clk1M) begin
    if (frame_done === 1'b1) done_count++;
    if (dq_pull_low === 1'b1) pull_count++;
    if (busy === 1'b1) busy_count++;
  end

  // Counts consecutive samples at level lvl, starting with the current one.
  task automatic measure_run(input logic lvl, output int len);
    len = 1;
    while (len < RUN_LIMIT) begin
      @(negedge clk1M);
      if (dq_pull_low !== lvl) break;
      len++;
    end
    if (len >= RUN_LIMIT) rx_timeout = 1'b1;
  endtask

  task automatic host_start(input int low_cycles);
    @(negedge clk1M);
    host_low = 1'b1;
    repeat (low_cycles) @(negedge clk1M);
    host_low = 1'b0;
  endtask

  // Called on the release sample; records presence timing and decodes nbits data bits.
  task automatic rx_frame(input int nbits);
    int lo, hi;
    rx_bits = '0; bad_bits = 0; rx_timeout = 1'b0;
    lat = 0; rl = 0; rh = 0; sl = 0;
    @(negedge clk1M);
    measure_run(1'b0, lat); if (rx_timeout) return;
    measure_run(1'b1, rl);  if (rx_timeout) return;
    measure_run(1'b0, rh);  if (rx_timeout) return;
    for (int i = 0; i < nbits; i++) begin
      measure_run(1'b1, lo); if (rx_timeout) return;
      measure_run(1'b0, hi); if (rx_timeout) return;
      rx_bits = {rx_bits[38:0], (hi > (T_ZERO + T_ONE) / 2)};
      if (lo != T_BIT_LOW || (hi != T_ZERO && hi != T_ONE)) bad_bits++;
    end
    if (nbits == 40) measure_run(1'b1, sl);
  endtask

  task automatic test_reset();
    @(negedge clk1M);
    vectors++; if (dq_pull_low !== 1'b0) begin miscompares++; $display("FAIL reset_pull: got %b, expected 0", dq_pull_low); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", frame_done); end
    rst = 1'b0;
    repeat (10) @(negedge clk1M);
    $display("reset: pull=%b busy=%b done=%b", dq_pull_low, busy, frame_done);
  endtask

  task automatic test_basic_frame_glitch();
    int d0, b0, p0;
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    d0 = done_count; b0 = busy_count; p0 = pull_count;
    host_start(18000);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_before_accept: got %b, expected 0", busy); end
    fork
      rx_frame(40);
      begin
        repeat (40) @(negedge clk1M);
        host_low = 1'b1;
        @(negedge clk1M);
        host_low = 1'b0;
      end
    join
    repeat (5) @(negedge clk1M);
    $display("basic frame: rx=%h lat=%0d resp=%0d/%0d stop=%0d", rx_bits, lat, rl, rh, sl);
    vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %b, expected 0", rx_timeout); end
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("FAIL basic_latency: got %0d, expected %0d", lat, EXP_LAT); end
    vectors++; if (rl !== T_RESP) begin miscompares++; $display("FAIL basic_resp_low: got %0d, expected %0d", rl, T_RESP); end
    vectors++; if (rh !== T_RESP) begin miscompares++; $display("FAIL basic_resp_high: got %0d, expected %0d", rh, T_RESP); end
    vectors++; if (rx_bits !== 40'h37_00_19_00_50) begin miscompares++; $display("FAIL basic_bits: got %h, expected 3700190050", rx_bits); end
    vectors++; if (bad_bits !== 0) begin miscompares++; $display("FAIL basic_bit_timing: got %0d bad bits, expected 0", bad_bits); end
    vectors++; if (sl !== T_BIT_LOW) begin miscompares++; $display("FAIL basic_stop_low: got %0d, expected %0d", sl, T_BIT_LOW); end
    vectors++; if (done_count - d0 !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_count - d0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b, expected 0", busy); end
    // 10 one-bits and 30 zero-bits in 0x3700190050
    vectors++; if (busy_count - b0 !== T_GO + 2*T_RESP + 41*T_BIT_LOW + 10*T_ONE + 30*T_ZERO) begin
      miscompares++; $display("FAIL basic_busy_cycles: got %0d, expected %0d", busy_count - b0, T_GO + 2*T_RESP + 41*T_BIT_LOW + 10*T_ONE + 30*T_ZERO);
    end
    vectors++; if (pull_count - p0 !== T_RESP + 41*T_BIT_LOW) begin
      miscompares++; $display("FAIL basic_pull_cycles: got %0d, expected %0d", pull_count - p0, T_RESP + 41*T_BIT_LOW);
    end
    repeat (20) @(negedge clk1M);
  endtask

  task automatic test_short_start();
    int d0, b0, p0;
    d0 = done_count; b0 = busy_count; p0 = pull_count;
    host_start(500);
    repeat (300) @(negedge clk1M);
    $display("short start: pull_cycles=%0d busy_cycles=%0d", pull_count - p0, busy_count - b0);
    vectors++; if (pull_count - p0 !== 0) begin miscompares++; $display("FAIL short_pull: got %0d cycles, expected 0", pull_count - p0); end
    vectors++; if (busy_count - b0 !== 0) begin miscompares++; $display("FAIL short_busy: got %0d cycles, expected 0", busy_count - b0); end
    vectors++; if (done_count - d0 !== 0) begin miscompares++; $display("FAIL short_done: got %0d, expected 0", done_count - d0); end
  endtask

  task automatic test_all_ones();
    int d0;
    hum_int = 8'hFF; hum_dec = 8'hFF; temp_int = 8'hFF; temp_dec = 8'hFF;
    d0 = done_count;
    host_start(10500);
    rx_frame(40);
    repeat (5) @(negedge clk1M);
    $display("all-ones frame: rx=%h lat=%0d stop=%0d", rx_bits, lat, sl);
    vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("FAIL ones_timeout: got %b, expected 0", rx_timeout); end
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("FAIL ones_latency: got %0d, expected %0d", lat, EXP_LAT); end
    vectors++; if (rx_bits !== 40'hFF_FF_FF_FF_FC) begin miscompares++; $display("FAIL ones_bits: got %h, expected fffffffffc", rx_bits); end
    vectors++; if (bad_bits !== 0) begin miscompares++; $display("FAIL ones_bit_timing: got %0d bad bits, expected 0", bad_bits); end
    vectors++; if (done_count - d0 !== 1) begin miscompares++; $display("FAIL ones_done_pulses: got %0d, expected 1", done_count - d0); end
    repeat (20) @(negedge clk1M);
  endtask

  task automatic test_reset_mid_frame();
    int d0, p0;
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    d0 = done_count;
    host_start(10500);
    rx_frame(20);
    repeat (10) @(negedge clk1M);
    vectors++; if (dq_pull_low !== 1'b1) begin miscompares++; $display("FAIL midrst_in_bit_low: got %b, expected 1", dq_pull_low); end
    rst = 1'b1;
    @(negedge clk1M);
    rst = 1'b0;
    vectors++; if (dq_pull_low !== 1'b0) begin miscompares++; $display("FAIL midrst_pull: got %b, expected 0", dq_pull_low); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    p0 = pull_count;
    repeat (200) @(negedge clk1M);
    $display("reset mid-frame: pull_after=%0d done=%0d", pull_count - p0, done_count - d0);
    vectors++; if (pull_count - p0 !== 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d pull cycles, expected 0", pull_count - p0); end
    vectors++; if (done_count - d0 !== 0) begin miscompares++; $display("FAIL midrst_done: got %0d, expected 0", done_count - d0); end
  endtask

  task automatic test_shadow_hold();
    int d0;
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    d0 = done_count;
    host_start(18000);
    fork
      rx_frame(40);
      begin
        repeat (300) @(negedge clk1M);
        hum_int = 8'h99;
        temp_dec = 8'h42;
      end
    join
    repeat (5) @(negedge clk1M);
    $display("shadow hold frame: rx=%h lat=%0d", rx_bits, lat);
    vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("FAIL shadow_timeout: got %b, expected 0", rx_timeout); end
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("FAIL shadow_latency: got %0d, expected %0d", lat, EXP_LAT); end
    vectors++; if (rx_bits !== 40'h37_00_19_00_50) begin miscompares++; $display("FAIL shadow_bits: got %h, expected 3700190050", rx_bits); end
    vectors++; if (done_count - d0 !== 1) begin miscompares++; $display("FAIL shadow_done_pulses: got %0d, expected 1", done_count - d0); end
  endtask

  initial begin
    repeat (4) @(negedge clk1M);
    test_reset();
    test_basic_frame_glitch();
    test_short_start();
    test_all_ones();
    test_reset_mid_frame();
    test_shadow_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
